// File: rtl/trace_capture.sv
// trace_capture: consumer end of the CPU write-back debug trace.
// Retirement events are buffered in a FIFO and replayed as 3-word records
// (pc, {seq, ena, reg}, value) on a 32-bit valid/ready stream, with
// retire/drop/overflow statistics alongside.
// Optional build macro: TRACE_FILTER_WB_EN -- store only retirements that
// actually write a register (non-writing ones are counted but never stored
// and never treated as drops).
module trace_capture #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture_en,
  input  logic             clr_stats,
  input  logic             wb_have_inst,
  input  logic [31:0]      wb_pc,
  input  logic             wb_ena,
  input  logic [4:0]       wb_reg,
  input  logic [31:0]      wb_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [31:0]      retire_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] seq;
    logic        ena;
    logic [4:0]  rd;
    logic [31:0] value;
  } entry_t;

  typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

  entry_t        mem [DEPTH];
  entry_t        hold;
  entry_t        new_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  state_t        state;
  state_t        state_next;
  logic          evt;
  logic          ena_eff;
  logic          store_evt;
  logic          push;
  logic          drop;
  logic          pop;

  assign evt     = capture_en && wb_have_inst;
  assign ena_eff = wb_ena && (wb_reg != 5'd0);

`ifdef TRACE_FILTER_WB_EN
  assign store_evt = evt && ena_eff;
`else
  assign store_evt = evt;
`endif

  // Fullness comes from the registered count, so a same-cycle pop never makes room.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign push       = store_evt && !fifo_full;
  assign drop       = store_evt && fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;

  // Build the entry for this cycle's event; seq is the pre-increment retire count.
  always_comb begin
    new_entry.pc    = wb_pc;
    new_entry.seq   = retire_cnt[15:0];
    new_entry.ena   = ena_eff;
    new_entry.rd    = wb_reg;
    new_entry.value = ena_eff ? wb_value : 32'd0;
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Statistics; a clear pulse wins over any event or drop in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else if (clr_stats) begin
      retire_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (evt) retire_cnt <= retire_cnt + 32'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  // Serializer state and the holding register loaded on each pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      state <= state_next;
      if (pop) hold <= mem[rd_ptr];
    end
  end

  // Serializer next state and stream outputs; words come straight from hold so they stay stable under stalls.
  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_data   = 32'd0;
    out_last   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_next = W0;
      end
      W0: begin
        out_valid = 1'b1;
        out_data  = hold.pc;
        if (out_ready) state_next = W1;
      end
      W1: begin
        out_valid = 1'b1;
        out_data  = {hold.seq, 10'd0, hold.ena, hold.rd};
        if (out_ready) state_next = W2;
      end
      W2: begin
        out_valid = 1'b1;
        out_data  = hold.value;
        out_last  = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: scoreboard bench for trace_capture.
// Expected stream words are queued as events are driven and compared against
// every valid stream cycle, so stalled words must match the queue head too.
module tb_trace_capture;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

`ifdef TRACE_FILTER_WB_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             capture_en;
  logic             clr_stats;
  logic             wb_have_inst;
  logic [31:0]      wb_pc;
  logic             wb_ena;
  logic [4:0]       wb_reg;
  logic [31:0]      wb_value;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_last;
  logic             fifo_empty;
  logic             fifo_full;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic [31:0]      retire_cnt;

  word_t       exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          records_done = 0;
  logic [31:0] model_retire = 32'd0;
  bit          rand_done = 1'b0;
  int          rand_sent;
  int          guard;
  int          n;
  logic [31:0] r_pc;
  logic [31:0] r_val;
  logic        r_ena;
  logic [4:0]  r_rd;
  logic        r_keep;

  always #5 clk = ~clk;

  trace_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .clr_stats(clr_stats),
    .wb_have_inst(wb_have_inst), .wb_pc(wb_pc), .wb_ena(wb_ena), .wb_reg(wb_reg),
    .wb_value(wb_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .overflow(overflow), .drop_cnt(drop_cnt),
    .retire_cnt(retire_cnt)
  );

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Queue the three words a stored event must produce.
  task automatic pushRecord(input logic [31:0] pc, input logic [15:0] seq, input logic ena_eff,
                            input logic [4:0] rd, input logic [31:0] value);
    word_t w;
    w.data = pc;                          w.last = 1'b0; exp_q.push_back(w);
    w.data = {seq, 10'd0, ena_eff, rd};   w.last = 1'b0; exp_q.push_back(w);
    w.data = ena_eff ? value : 32'd0;     w.last = 1'b1; exp_q.push_back(w);
  endtask

  // Drive one retirement for one cycle; 'stored' says whether space is expected.
  task automatic applyStimulus(input logic [31:0] pc, input logic ena, input logic [4:0] rd,
                               input logic [31:0] value, input bit stored, input bit clr);
    logic ena_eff;
    ena_eff = ena && (rd != 5'd0);
    if (stored && (!FILTER || ena_eff)) pushRecord(pc, model_retire[15:0], ena_eff, rd, value);
    capture_en   = 1'b1;
    wb_have_inst = 1'b1;
    wb_pc        = pc;
    wb_ena       = ena;
    wb_reg       = rd;
    wb_value     = value;
    clr_stats    = clr;
    @(posedge clk); #1;
    wb_have_inst = 1'b0;
    clr_stats    = 1'b0;
    model_retire = clr ? 32'd0 : model_retire + 32'd1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Wait (bounded) until every expected word has left the DUT.
  task automatic waitDrain(input int limit);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < limit) begin
      tick();
      k++;
    end
    checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
    checkOutput("drain_empty", 32'(fifo_empty), 32'd1);
  endtask

  // Stalled stream: DEPTH+3 back-to-back events, the last two must drop.
  task automatic burstOverflow();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      applyStimulus(32'h1000_0000 + 32'(i * 4), 1'b1, 5'(i % 31 + 1),
                    32'h5A00_0000 + 32'(i), (i < DEPTH + 1), 1'b0);
    end
    checkOutput("ovf_full", 32'(fifo_full), 32'd1);
    checkOutput("ovf_valid", 32'(out_valid), 32'd1);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
  endtask

  // Stream monitor: every valid word must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      checkOutput("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        checkOutput("out_data", out_data, exp_q[0].data);
        checkOutput("out_last", 32'(out_last), 32'(exp_q[0].last));
        if (out_ready === 1'b1) begin
          if (exp_q[0].last) records_done++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed and random test sequence.
  initial begin
    rst_n = 1'b0; capture_en = 1'b0; clr_stats = 1'b0; wb_have_inst = 1'b0;
    wb_pc = '0; wb_ena = 1'b0; wb_reg = '0; wb_value = '0; out_ready = 1'b1;
    tick(); tick();
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", out_data, 32'd0);
    checkOutput("rst_last", 32'(out_last), 32'd0);
    checkOutput("rst_empty", 32'(fifo_empty), 32'd1);
    checkOutput("rst_full", 32'(fifo_full), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
    checkOutput("rst_retire", retire_cnt, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] single event and latency");
    applyStimulus(32'h0000_0000, 1'b1, 5'd5, 32'h0000_0010, 1'b1, 1'b0);
    checkOutput("lat_n1_valid", 32'(out_valid), 32'd0);
    checkOutput("lat_n1_empty", 32'(fifo_empty), 32'd0);
    tick();
    checkOutput("lat_n2_valid", 32'(out_valid), 32'd1);
    waitDrain(50);
    checkOutput("single_retire", retire_cnt, 32'd1);

    $display("[TB] write to x0");
    applyStimulus(32'h0000_0100, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    waitDrain(50);
    checkOutput("x0_retire", retire_cnt, model_retire);
    checkOutput("x0_drop", 32'(drop_cnt), 32'd0);

    $display("[TB] capture disabled");
    capture_en = 1'b0; wb_have_inst = 1'b1; wb_ena = 1'b1; wb_reg = 5'd3;
    tick(); tick();
    checkOutput("dis_retire", retire_cnt, model_retire);
    checkOutput("dis_empty", 32'(fifo_empty), 32'd1);
    wb_have_inst = 1'b0; capture_en = 1'b1;

    $display("[TB] overflow from reset");
    rst_n = 1'b0; tick(); exp_q.delete(); model_retire = 32'd0; rst_n = 1'b1;
    burstOverflow();
    checkOutput("ovf_retire", retire_cnt, 32'd11);
    out_ready = 1'b1;
    waitDrain(200);

    $display("[TB] random stalls, 100 records");
    records_done = 0;
    rand_sent = 0;
    guard = 0;
    fork
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
      begin
        while (rand_sent < 100 && guard < 20000) begin
          guard++;
          if ((rand_sent - records_done) < 8 && $urandom_range(0, 1) == 0) begin
            r_pc  = $urandom;
            r_val = $urandom;
            r_ena = 1'($urandom_range(0, 1));
            r_rd  = 5'($urandom_range(0, 31));
            r_keep = !FILTER || (r_ena && r_rd != 5'd0);
            applyStimulus(r_pc, r_ena, r_rd, r_val, 1'b1, 1'b0);
            if (r_keep) rand_sent++;
          end else begin
            tick();
          end
        end
        checkOutput("rand_sent", 32'(rand_sent), 32'd100);
        waitDrain(5000);
        checkOutput("rand_records", 32'(records_done), 32'd100);
        rand_done = 1'b1;
      end
    join
    tick();

    $display("[TB] reset while in W1");
    out_ready = 1'b0;
    applyStimulus(32'h0000_2000, 1'b1, 5'd3, 32'h1234_5678, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    checkOutput("w0_reached", 32'(out_valid), 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checkOutput("w1_last", 32'(out_last), 32'd0);
    rst_n = 1'b0; tick(); exp_q.delete(); model_retire = 32'd0;
    checkOutput("w1rst_valid", 32'(out_valid), 32'd0);
    checkOutput("w1rst_empty", 32'(fifo_empty), 32'd1);
    checkOutput("w1rst_retire", retire_cnt, 32'd0);
    checkOutput("w1rst_drop", 32'(drop_cnt), 32'd0);
    checkOutput("w1rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    applyStimulus(32'h0000_3000, 1'b1, 5'd7, 32'h0000_00AA, 1'b1, 1'b0);
    waitDrain(50);

    $display("[TB] clear coinciding with event");
    burstOverflow();
    out_ready = 1'b1;
    waitDrain(200);
    applyStimulus(32'h0000_4000, 1'b1, 5'd9, 32'hCAFE_0001, 1'b1, 1'b1);
    checkOutput("clr_retire", retire_cnt, 32'd0);
    checkOutput("clr_drop", 32'(drop_cnt), 32'd0);
    checkOutput("clr_overflow", 32'(overflow), 32'd0);
    waitDrain(50);
    applyStimulus(32'h0000_4004, 1'b1, 5'd10, 32'hCAFE_0002, 1'b1, 1'b0);
    waitDrain(50);
    checkOutput("post_clr_retire", retire_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Consumer end of the CPU write-back debug trace (debug_wb_have_inst/pc/ena/reg/value).
- Samples one retirement event per cycle and buffers events in a FIFO.
- Serialises each event as a 3-word record on a 32-bit valid/ready stream to a host or logger.
- Keeps retirement, drop and overflow statistics for the bench and the board debug path.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
CNT_W, 16, width of drop counter

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
capture_en  in  1  1 = sample trace events; 0 = ignore inputs
clr_stats  in  1  1-cycle pulse: clear retire_cnt, drop_cnt, overflow
wb_have_inst  in  1  retirement valid from CPU
wb_pc  in  32  retired PC
wb_ena  in  1  register write enable
wb_reg  in  5  destination register
wb_value  in  32  write-back value
out_valid  out  1  stream word valid
out_ready  in  1  sink accepts word
out_data  out  32  stream word
out_last  out  1  high on word 2 of a record
fifo_empty  out  1  FIFO holds no entries
fifo_full  out  1  FIFO holds DEPTH entries
overflow  out  1  sticky: at least one event dropped
drop_cnt  out  CNT_W  dropped events, saturating
retire_cnt  out  32  accepted-or-dropped retirements, wraps

Behaviour:
- Reset: the only reset is rst_n low at a rising clk edge.
  - All outputs 0 except fifo_empty=1.
  - FIFO pointers, count and serializer state cleared.
  - A partially sent record is discarded; no resumption.
- Event: capture_en && wb_have_inst in a cycle.
  - Each event increments retire_cnt by 1, mod 2^32, whether or not the event is stored.
  - Effective write enable: ena_eff = wb_ena && (wb_reg != 0).
- Entry contents:
  - pc.
  - seq = retire_cnt[15:0] before the increment.
  - ena_eff.
  - reg.
  - value, forced to 0 when ena_eff=0.
- Push: the event is written at the end of its cycle if the registered count < DEPTH.
  - Fullness uses the registered count from before any same-cycle pop.
  - An event arriving while full is dropped even if a pop happens in the same cycle.
  - On a drop: overflow <= 1; drop_cnt increments, saturating at all-ones.
- clr_stats coinciding with an event: clear wins for retire_cnt, drop_cnt and overflow.
  - The event is still pushed if space exists, with seq = pre-clear value.
- Serializer FSM, states IDLE, W0, W1, W2:
  - IDLE: if FIFO not empty, pop the head into the holding register and go to W0. out_valid=0.
  - W0: out_data=pc. On out_valid && out_ready go to W1.
  - W1: out_data={seq[15:0], 10'b0, ena_eff, reg[4:0]}. On handshake go to W2.
  - W2: out_data=value, out_last=1. On handshake return to IDLE.
  - No back-to-back pop from W2, so each record is followed by one idle cycle.
- Stream rules:
  - out_valid=1 in W0, W1 and W2.
  - out_data and out_last are held stable while out_valid && !out_ready.
  - out_valid never drops without a handshake, except on reset.
- Latency, empty system with out_ready=1:
  - Event in cycle N.
  - FIFO non-empty in N+1.
  - Word 0 valid in N+2.
  - Word 2 accepted in N+4.
- Sustained rate: 1 record per 4 cycles. Sustained retirements at 1 per cycle eventually overflow; this is by design.
- capture_en=0: no pushes and no counting. The FIFO and serializer keep draining.
- fifo_full and fifo_empty are derived from the registered count, not from pointer equality alone.

Optional Feature:
TRACE_FILTER_WB_EN
- Defined: only events with ena_eff=1 are pushed.
  - Non-writing retirements (stores, branches, writes to x0) still increment retire_cnt and are never counted as drops.
  - Gaps in seq then expose filtered instructions.
- Undefined: every retirement is pushed, as described in Behaviour.

Test Plan:
- Reset, then a single event pc=0x0000_0000, ena=1, reg=5, value=0x0000_0010, out_ready=1 -> words 0x0000_0000, 0x0000_0025, 0x0000_0010, last=1 on word 2; word 0 valid 2 cycles after the event; retire_cnt=1.
- Event with ena=1, reg=0, value=0xDEAD_BEEF -> word 1 = 0x0000_0000 and word 2 = 0x0000_0000. With TRACE_FILTER_WB_EN: no record output; retire_cnt still increments; drop_cnt=0.
- out_ready=0 while DEPTH+3=11 consecutive events arrive (DEPTH=8) -> 1 entry in the holding register, 8 in the FIFO, fifo_full=1, 2 dropped, overflow=1, drop_cnt=2, retire_cnt=11.
  - Then out_ready=1: 9 records with seq 0..8; last word-1 seq field = 0x0008.
- Random out_ready stalls mid-record -> out_data and out_last are unchanged across every stall cycle; word order is preserved for 100 records.
- rst_n=0 for one edge while in W1 -> next cycle out_valid=0, fifo_empty=1, all counters 0; the next event produces a record with seq=0.
- clr_stats in the same cycle as an event with the FIFO not full -> record is pushed with the old seq; afterwards retire_cnt=0, drop_cnt=0, overflow=0.
